// File: rtl/cbs_pkg.sv
// Shared CBS datapath definitions: default sample/coordinate widths, the signed max
// used by the pooling stage, and the per-input classification used by the pooler.
package cbs_pkg;

   localparam int CBS_DATA_W = 19;
   localparam int CBS_CNT_W  = 15;
   localparam int CBS_MAX_W  = 32;

   typedef logic signed [CBS_MAX_W-1:0] cbs_wide_t;

   // Role of one accepted input inside its 2x2 pooling window.
   typedef enum logic [1:0] {
      PIX_DROP     = 2'd0,
      PIX_EVEN_COL = 2'd1,
      PIX_TOP_PAIR = 2'd2,
      PIX_BOT_PAIR = 2'd3
   } pix_kind_e;

   // Narrower samples are sign-extended into the wide type by the caller.
   function automatic cbs_wide_t max_signed(input cbs_wide_t a, input cbs_wide_t b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Half-width line buffer for 2x2 pooling: one synchronous write port, one
// combinational read port so the odd-row result is ready in the same cycle.
module pool_line_buf #(
   parameter int DATA_W = 19,
   parameter int DEPTH  = 208,
   parameter int AW     = 8
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [AW-1:0]     rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/cbs_maxpool2x2.sv
// 2x2 stride-2 max pooling of the coordinate-tagged CBS result stream; even-row
// horizontal maxima wait in a half-width line buffer for their odd-row partner.
module cbs_maxpool2x2
   import cbs_pkg::*;
#(
   parameter int DATA_W = CBS_DATA_W,
   parameter int CNT_W  = CBS_CNT_W,
   parameter int IMG_W  = 416,
   parameter int IMG_H  = 416
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   input  logic signed [DATA_W-1:0] in_data,
   input  logic [CNT_W-1:0]         in_row,
   input  logic [CNT_W-1:0]         in_col,
   output logic                     out_valid,
   output logic signed [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]         out_row,
   output logic [CNT_W-1:0]         out_col,
   output logic                     frame_done
);

   localparam int OUT_W = IMG_W / 2;
   localparam int OUT_H = IMG_H / 2;
   localparam int AW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;

   localparam logic [CNT_W-1:0] COL_LIM  = CNT_W'(2 * OUT_W);
   localparam logic [CNT_W-1:0] ROW_LIM  = CNT_W'(2 * OUT_H);
   localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(OUT_W - 1);
   localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(OUT_H - 1);

   function automatic logic signed [DATA_W-1:0] smax(input logic signed [DATA_W-1:0] a,
                                                     input logic signed [DATA_W-1:0] b);
      return DATA_W'(max_signed(CBS_MAX_W'(a), CBS_MAX_W'(b)));
   endfunction

   logic signed [DATA_W-1:0] h;
   logic signed [DATA_W-1:0] p;
   logic signed [DATA_W-1:0] lbuf_rd;
   logic signed [DATA_W-1:0] pooled;
   logic [OUT_W-1:0]         vbit;
   logic [AW-1:0]            idx;
   logic                     last_blk;
   pix_kind_e                kind;

   // The trailing odd column/row of an odd-sized map falls outside the limits and is dropped.
   always_comb begin
      kind = PIX_DROP;
      if (in_valid && (in_col < COL_LIM) && (in_row < ROW_LIM)) begin
         if (!in_col[0]) begin
            kind = PIX_EVEN_COL;
         end else if (!in_row[0]) begin
            kind = PIX_TOP_PAIR;
         end else begin
            kind = PIX_BOT_PAIR;
         end
      end
   end

   assign idx      = in_col[AW:1];
   assign p        = smax(h, in_data);
   assign pooled   = smax(lbuf_rd, p);
   assign last_blk = ((in_row >> 1) == LAST_ROW) && ((in_col >> 1) == LAST_COL);

   pool_line_buf #(
      .DATA_W (DATA_W),
      .DEPTH  (OUT_W),
      .AW     (AW)
   ) u_lbuf (
      .clk     (clk),
      .wr_en   (kind == PIX_TOP_PAIR),
      .wr_addr (idx),
      .wr_data (p),
      .rd_addr (idx),
      .rd_data (lbuf_rd)
   );

   // vbit guards each buffered pair so a reset mid-frame can never combine stale data.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         h          <= '0;
         vbit       <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_row    <= '0;
         out_col    <= '0;
         frame_done <= 1'b0;
      end else begin
         out_valid  <= 1'b0;
         frame_done <= 1'b0;
         case (kind)
            PIX_EVEN_COL: h <= in_data;
            PIX_TOP_PAIR: vbit[idx] <= 1'b1;
            PIX_BOT_PAIR: begin
               if (vbit[idx]) begin
                  out_valid  <= 1'b1;
                  out_data   <= pooled;
                  out_row    <= in_row >> 1;
                  out_col    <= in_col >> 1;
                  frame_done <= last_blk;
                  vbit[idx]  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cbs_maxpool2x2.sv
// Self-checking bench for cbs_maxpool2x2: vector table, directed corner sequences
// and random frames against a frame-level pooling reference.
module tb_cbs_maxpool2x2;

   localparam int DW = 19;
   localparam int CW = 15;

   typedef logic signed [DW-1:0] samp_t;

   typedef struct {
      logic [CW-1:0] row;
      logic [CW-1:0] col;
      samp_t         data;
      bit            exp_v;
      samp_t         exp_d;
      logic [CW-1:0] exp_r;
      logic [CW-1:0] exp_c;
      bit            exp_done;
   } vec_t;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          in_valid = 1'b0;
   samp_t         in_data = '0;
   logic [CW-1:0] in_row = '0;
   logic [CW-1:0] in_col = '0;

   logic          out_valid, frame_done;
   samp_t         out_data;
   logic [CW-1:0] out_row, out_col;
   logic          o53_valid, o53_done;
   samp_t         o53_data;
   logic [CW-1:0] o53_row, o53_col;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   cbs_maxpool2x2 #(.DATA_W(DW), .CNT_W(CW), .IMG_W(4), .IMG_H(4)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_row(in_row), .in_col(in_col), .out_valid(out_valid), .out_data(out_data),
      .out_row(out_row), .out_col(out_col), .frame_done(frame_done));

   cbs_maxpool2x2 #(.DATA_W(DW), .CNT_W(CW), .IMG_W(5), .IMG_H(3)) dut53 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_row(in_row), .in_col(in_col), .out_valid(o53_valid), .out_data(o53_data),
      .out_row(o53_row), .out_col(o53_col), .frame_done(o53_done));

   task automatic check(input string name, input logic signed [31:0] act,
                        input logic signed [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic samp_t smax2(input samp_t a, input samp_t b);
      return (a > b) ? a : b;
   endfunction

   // Cycle-level reference for the 4x4 instance: a block emits on its bottom-right
   // pixel only if its top pair arrived since the last reset and was not yet used.
   samp_t         pix [0:3][0:3];
   bit            top_seen [0:1][0:1];
   bit            m_v = 1'b0, m_done = 1'b0;
   samp_t         m_d = '0;
   logic [CW-1:0] m_r = '0, m_c = '0;
   int            mr, mc;
   bit            mon_en = 1'b0;

   initial forever begin
      @(posedge clk or negedge reset);
      m_v    = 1'b0;
      m_done = 1'b0;
      if (!reset) begin
         m_d = '0; m_r = '0; m_c = '0;
         foreach (top_seen[a, b]) top_seen[a][b] = 1'b0;
      end else if (in_valid && in_row < 4 && in_col < 4) begin
         mr = int'(in_row);
         mc = int'(in_col);
         pix[mr][mc] = in_data;
         if (mc % 2 == 1) begin
            if (mr % 2 == 0) begin
               top_seen[mr/2][mc/2] = 1'b1;
            end else if (top_seen[mr/2][mc/2]) begin
               m_v    = 1'b1;
               m_d    = smax2(smax2(pix[mr-1][mc-1], pix[mr-1][mc]),
                              smax2(pix[mr][mc-1], pix[mr][mc]));
               m_r    = CW'(mr / 2);
               m_c    = CW'(mc / 2);
               m_done = (mr == 3) && (mc == 3);
               top_seen[mr/2][mc/2] = 1'b0;
            end
         end
      end
   end

   samp_t log4[$];
   samp_t log53[$];
   samp_t exp_q[$];
   int    done4 = 0;
   int    done53 = 0;

   initial forever begin
      @(negedge clk);
      if (mon_en) begin
         check("mon out_valid", out_valid, m_v);
         check("mon frame_done", frame_done, m_done);
         check("mon out_data", out_data, m_d);
         check("mon out_row", out_row, m_r);
         check("mon out_col", out_col, m_c);
      end
      if (reset && out_valid) log4.push_back(out_data);
      if (reset && frame_done) done4++;
      if (reset && o53_valid) log53.push_back(o53_data);
      if (reset && o53_done) done53++;
   end

   samp_t frm [0:3][0:3];

   task automatic step(input bit v, input int r, input int c, input samp_t d);
      @(posedge clk);
      #3;
      in_valid = v;
      in_row   = CW'(r);
      in_col   = CW'(c);
      in_data  = d;
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 0, 0, '0);
   endtask

   task automatic assert_reset();
      @(posedge clk);
      #3;
      reset    = 1'b0;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #3;
   endtask

   task automatic release_reset();
      reset = 1'b1;
   endtask

   task automatic clear_logs();
      log4.delete(); log53.delete(); exp_q.delete();
      done4 = 0; done53 = 0;
   endtask

   task automatic random_frame();
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            frm[r][c] = samp_t'($urandom);
   endtask

   // Frame-level reference: the max of each 2x2 block, in raster order of blocks.
   task automatic push_expected();
      for (int br = 0; br < 2; br++)
         for (int bc = 0; bc < 2; bc++)
            exp_q.push_back(smax2(smax2(frm[2*br][2*bc], frm[2*br][2*bc+1]),
                                  smax2(frm[2*br+1][2*bc], frm[2*br+1][2*bc+1])));
   endtask

   task automatic send_frame(input int gap, input int rand_gap_max);
      push_expected();
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            step(1'b1, r, c, frm[r][c]);
            if (gap > 0) idle(gap);
            else if (rand_gap_max > 0) idle(int'($urandom_range(0, rand_gap_max)));
         end
   endtask

   task automatic check_log(input string name, input int exp_done);
      check({name, " count"}, log4.size(), exp_q.size());
      for (int i = 0; i < log4.size() && i < exp_q.size(); i++)
         check($sformatf("%s out[%0d]", name, i), log4[i], exp_q[i]);
      check({name, " frame_done count"}, done4, exp_done);
      clear_logs();
   endtask

   task automatic applyStimulus(input vec_t v);
      step(1'b1, int'(v.row), int'(v.col), v.data);
   endtask

   task automatic checkOutput(input vec_t v, input int i);
      check($sformatf("vec%0d out_valid", i), out_valid, v.exp_v);
      check($sformatf("vec%0d frame_done", i), frame_done, v.exp_done);
      if (v.exp_v) begin
         check($sformatf("vec%0d out_data", i), out_data, v.exp_d);
         check($sformatf("vec%0d out_row", i), out_row, v.exp_r);
         check($sformatf("vec%0d out_col", i), out_col, v.exp_c);
      end
   endtask

   function automatic vec_t mk(input int r, input int c, input int d);
      vec_t v;
      v.row = CW'(r); v.col = CW'(c); v.data = samp_t'(d);
      v.exp_v = 1'b0; v.exp_d = '0; v.exp_r = '0; v.exp_c = '0; v.exp_done = 1'b0;
      return v;
   endfunction

   vec_t tbl [20];

   initial begin
      // 4x4 ramp 0..15 followed by one all-negative block in rows 0/1.
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            tbl[r*4+c] = mk(r, c, r*4+c);
      tbl[5].exp_v  = 1'b1; tbl[5].exp_d  = 5;  tbl[5].exp_r  = 0; tbl[5].exp_c  = 0;
      tbl[7].exp_v  = 1'b1; tbl[7].exp_d  = 7;  tbl[7].exp_r  = 0; tbl[7].exp_c  = 1;
      tbl[13].exp_v = 1'b1; tbl[13].exp_d = 13; tbl[13].exp_r = 1; tbl[13].exp_c = 0;
      tbl[15].exp_v = 1'b1; tbl[15].exp_d = 15; tbl[15].exp_r = 1; tbl[15].exp_c = 1;
      tbl[15].exp_done = 1'b1;
      tbl[16] = mk(0, 0, -3);
      tbl[17] = mk(0, 1, -7);
      tbl[18] = mk(1, 0, -1);
      tbl[19] = mk(1, 1, -100);
      tbl[19].exp_v = 1'b1; tbl[19].exp_d = -1;

      $display("[TB] reset state");
      assert_reset();
      check("reset out_valid", out_valid, 0);
      check("reset out_data", out_data, 0);
      check("reset out_row", out_row, 0);
      check("reset out_col", out_col, 0);
      check("reset frame_done", frame_done, 0);
      release_reset();
      mon_en = 1'b1;

      $display("[TB] vector table");
      for (int i = 0; i < 20; i++) begin
         applyStimulus(tbl[i]);
         if (i > 0) checkOutput(tbl[i-1], i-1);
      end
      idle(1);
      checkOutput(tbl[19], 19);
      idle(1);
      clear_logs();

      $display("[TB] odd dimensions 5x3");
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 5; c++)
            step(1'b1, r, c, samp_t'(9));
      idle(2);
      check("odd count", log53.size(), 2);
      for (int i = 0; i < log53.size(); i++)
         check($sformatf("odd out[%0d]", i), log53[i], 9);
      check("odd frame_done count", done53, 1);
      check("odd last row", o53_row, 0);
      check("odd last col", o53_col, 1);

      $display("[TB] reset mid-frame");
      random_frame();
      clear_logs();
      for (int c = 0; c < 4; c++) step(1'b1, 0, c, frm[0][c]);
      assert_reset();
      check("midreset out_data", out_data, 0);
      check("midreset out_valid", out_valid, 0);
      release_reset();
      for (int c = 0; c < 4; c++) step(1'b1, 1, c, frm[1][c]);
      idle(2);
      check("midreset row1 count", log4.size(), 0);
      clear_logs();
      send_frame(0, 0);
      idle(2);
      check_log("midreset restart", 1);

      $display("[TB] gapped stream");
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            frm[r][c] = samp_t'(r*4+c);
      send_frame(5, 0);
      idle(2);
      check_log("gapped", 1);

      $display("[TB] back-to-back frames");
      random_frame();
      send_frame(0, 0);
      random_frame();
      send_frame(0, 0);
      idle(2);
      check_log("b2b", 2);

      $display("[TB] random frames");
      for (int f = 0; f < 6; f++) begin
         random_frame();
         send_frame(0, 3);
         idle(2);
         check_log($sformatf("rand%0d", f), 1);
      end

      idle(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cbs_maxpool2x2.md
# cbs_maxpool2x2

Downstream stage of the CBS (Conv–BatchNorm–SiLU) block: consumes the stream of signed 19-bit CBS results tagged with row/column coordinates and produces a 2×2, stride-2 max-pooled feature map. This is the spatial downsampling path of the YOLOv7 MP stage. The block is fully streaming: one input accepted per cycle, with no backpressure. A half-width line buffer holds even-row horizontal maxima until the matching odd row arrives.

## Interface
Parameters:
- DATA_W, 19: sample width, signed two's complement; matches the CBS result width.
- CNT_W, 15: row/column coordinate width.
- IMG_W, 416: input feature-map width in pixels.
- IMG_H, 416: input feature-map height in pixels.

Ports:
- clk, input, 1: clock.
- reset, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: one-cycle strobe; in_data/in_row/in_col are valid (CBS result-ready strobe).
- in_data, input, DATA_W: signed CBS result.
- in_row, input, CNT_W: row of in_data, 0..IMG_H-1.
- in_col, input, CNT_W: column of in_data, 0..IMG_W-1.
- out_valid, output, 1: one-cycle strobe for a pooled sample.
- out_data, output, DATA_W: signed pooled maximum.
- out_row, output, CNT_W: pooled row = in_row>>1.
- out_col, output, CNT_W: pooled column = in_col>>1.
- frame_done, output, 1: one-cycle pulse, coincident with out_valid for the last pooled sample (row (IMG_H/2)-1, col (IMG_W/2)-1).

## Operation
- Coordinates come only from in_row/in_col. There are no internal position counters. Inputs are assumed raster-ordered per frame.
- Even in_col: latch in_data into the pair register `h`.
- Odd in_col: compute `p = max_signed(h, in_data)`.
  - Even in_row: write `p` to `lbuf[in_col>>1]` and set `vbit[in_col>>1]`.
  - Odd in_row: if `vbit[in_col>>1]`, emit `max_signed(lbuf[in_col>>1], p)`, then clear that vbit. Otherwise suppress the output.
- Odd IMG_W: the last column is ignored, giving a floor(IMG_W/2) output width. Odd IMG_H: the last row is ignored. Ignored inputs produce no side effects.
- Coordinates with in_col ≥ 2·floor(IMG_W/2) or in_row ≥ 2·floor(IMG_H/2) are dropped.
- All comparisons are signed. Ties select either operand; values are identical in that case. No saturation is needed, since max does not widen.
- in_valid=0 means hold state; `h`, lbuf and vbit are unchanged.
- Reset (asynchronous assert, synchronous release):
  - out_valid=0, out_data=0, out_row=0, out_col=0, frame_done=0.
  - `h`=0 and all vbits cleared.
  - lbuf data is not reset.
- Reset mid-frame: vbits cleared, so no odd-row output can combine stale data. The stream resumes cleanly from the next even row.

## Timing
- Latency: out_valid asserts exactly 1 cycle after the in_valid cycle carrying an odd-row, odd-column input.
- Output registers hold their value until the next emission. Only out_valid and frame_done are pulses.
- Throughput: in_valid may assert every cycle.
  - lbuf needs one read and one write per cycle at most. Read and write to the same address never coincide, since an entry is either written (even row) or read (odd row).
  - The read is combinational, or registered with a 1-cycle pre-read issued at the even-column input. Either way, the 1-cycle output latency must hold.
- Back-to-back frames: row 0 of frame N+1 may follow the last input of frame N with no gap cycle.

## Structure
- `cbs_pkg`: DATA_W and CNT_W defaults and the signed-max function, shared with the CBS block.
- Sub-module `pool_line_buf`: simple dual-port RAM, floor(IMG_W/2)×DATA_W, with a write port and a read port. The vbit vector stays in the top level, because it must reset.
- Top level contains the pair register, compare logic, vbit vector and output registers. Expected size is about 150–250 lines.

## Test plan
- 4×4 frame, values 0..15 in raster order. Expected outputs: (0,0)=5, (0,1)=7, (1,0)=13, (1,1)=15. Each arrives 1 cycle after its odd/odd input, and frame_done pulses with (1,1).
- Negative values: 2×2 block {-3,-7,-1,-100} gives out_data=-1, confirming the comparison is signed rather than unsigned.
- Odd dimensions: IMG_W=5, IMG_H=3, with every input 9. Expect exactly 2 outputs, both 9. Column 4 and row 2 produce nothing.
- Reset mid-frame: assert reset after row 0 of a 4×4 frame, then release and resume at row 1. Expect no outputs for row 1, all outputs at 0, then a correct full frame after restarting at row 0.
- Gapped stream: in_valid every 6th cycle (clk6 cadence) on a 4×4 frame. Expect the same 4 values as the back-to-back case, with out_valid 1 cycle after each odd/odd strobe.
- Two back-to-back 4×4 frames with different data: expect 8 outputs and 2 frame_done pulses, with no cross-frame contamination.
